// File: rtl/yarp_dmem_bus_if_if.sv
// Data-memory system bus: request/grant/response handshake between the
// yarp load/store adapter (master) and the memory fabric (slave).
interface yarp_dmem_bus_if_if;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic        bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_i;

  modport master (
    output bus_req_o, bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
  );

  modport slave (
    input  bus_req_o, bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
  );
endinterface

// File: rtl/yarp_dmem_bus_if.sv
// Converts yarp core byte/half/word load-store requests into aligned 32-bit
// bus transactions, with misalignment checking and a response timeout.
module yarp_dmem_bus_if #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      data_mem_req_i,
  input  logic [31:0]               data_mem_addr_i,
  input  logic [1:0]                data_mem_byte_en_i,
  input  logic                      data_mem_wr_i,
  input  logic [31:0]               data_mem_wr_data_i,
  output logic [31:0]               mem_rd_data_o,
  output logic                      mem_stall_o,
  output logic                      data_err_o,
  yarp_dmem_bus_if_if.master        bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [1:0]  size_q, size_d;
  logic        wr_q, wr_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] baddr_q, baddr_d;
  logic [3:0]  bbe_q, bbe_d;
  logic [31:0] bwdata_q, bwdata_d;
  logic        bwe_q, bwe_d;

  logic        legal;
  logic        timeout;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] rd_shifted;
  logic [31:0] rd_extract;

  always_comb begin
    legal      = 1'b0;
    be_calc    = 4'b1111;
    wdata_calc = data_mem_wr_data_i;
    unique case (data_mem_byte_en_i)
      2'b00: begin
        legal      = 1'b1;
        be_calc    = 4'b0001 << data_mem_addr_i[1:0];
        wdata_calc = {4{data_mem_wr_data_i[7:0]}};
      end
      2'b01: begin
        legal      = ~data_mem_addr_i[0];
        be_calc    = 4'b0011 << data_mem_addr_i[1:0];
        wdata_calc = {2{data_mem_wr_data_i[15:0]}};
      end
      2'b11:   legal = (data_mem_addr_i[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  // Load data is shifted down to the accessed lane, then zero-filled by size.
  always_comb begin
    rd_shifted = bus.bus_rdata_i >> {addr_lo_q, 3'b000};
    unique case (size_q)
      2'b00:   rd_extract = {24'h0, rd_shifted[7:0]};
      2'b01:   rd_extract = {16'h0, rd_shifted[15:0]};
      default: rd_extract = rd_shifted;
    endcase
  end

  assign timeout = (cnt_q >= TO_LAST);

  always_comb begin
    state_d   = state_q;
    addr_lo_d = addr_lo_q;
    size_d    = size_q;
    wr_d      = wr_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    baddr_d   = baddr_q;
    bbe_d     = bbe_q;
    bwdata_d  = bwdata_q;
    bwe_d     = bwe_q;
    unique case (state_q)
      IDLE: begin
        if (data_mem_req_i) begin
          addr_lo_d = data_mem_addr_i[1:0];
          size_d    = data_mem_byte_en_i;
          wr_d      = data_mem_wr_i;
          if (legal) begin
            state_d  = REQ;
            err_d    = 1'b0;
            cnt_d    = '0;
            baddr_d  = {data_mem_addr_i[31:2], 2'b00};
            bbe_d    = be_calc;
            bwdata_d = wdata_calc;
            bwe_d    = data_mem_wr_i;
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (bus.bus_gnt_i) begin
          state_d = WAIT_RESP;
        end else if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      WAIT_RESP: begin
        cnt_d = cnt_q + 8'd1;
        if (bus.bus_rvalid_i) begin
          state_d = DONE;
          err_d   = bus.bus_err_i;
          if (!wr_q) rdata_d = rd_extract;
        end else if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      addr_lo_q <= '0;
      size_q    <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      baddr_q   <= '0;
      bbe_q     <= '0;
      bwdata_q  <= '0;
      bwe_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_lo_q <= addr_lo_d;
      size_q    <= size_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      baddr_q   <= baddr_d;
      bbe_q     <= bbe_d;
      bwdata_q  <= bwdata_d;
      bwe_q     <= bwe_d;
    end
  end

  assign bus.bus_req_o   = (state_q == REQ);
  assign bus.bus_addr_o  = baddr_q;
  assign bus.bus_be_o    = bbe_q;
  assign bus.bus_wdata_o = bwdata_q;
  assign bus.bus_we_o    = bwe_q;

  assign mem_rd_data_o = rdata_q;
  assign mem_stall_o   = data_mem_req_i && (state_q != DONE);
  assign data_err_o    = (state_q == DONE) && err_q;

endmodule

// File: doc/yarp_dmem_bus_if.md
YARP_DMEM_BUS_IF -- requirements
Module: yarp_dmem_bus_if

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of cycles spent waiting in REQ or WAIT_RESP before an error is raised (allowed range 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port data_mem_req_i  input  1  core memory request, held high until mem_stall_o is seen low.
REQ-005 SHALL have port data_mem_addr_i  input  32  byte address.
REQ-006 SHALL have port data_mem_byte_en_i  input  2  access size: 2'b00 byte, 2'b01 half-word, 2'b11 word; 2'b10 is illegal.
REQ-007 SHALL have port data_mem_wr_i  input  1  1 = store, 0 = load.
REQ-008 SHALL have port data_mem_wr_data_i  input  32  store data, LSB-aligned.
REQ-009 SHALL have ports mem_rd_data_o output 32 (load data, LSB-aligned, unextended), mem_stall_o output 1 (core must hold request) and data_err_o output 1 (one-cycle error pulse).
REQ-010 SHALL have bus ports bus_req_o out 1, bus_addr_o out 32, bus_we_o out 1, bus_be_o out 4, bus_wdata_o out 32, bus_gnt_i in 1, bus_rvalid_i in 1, bus_rdata_i in 32, bus_err_i in 1.

Function
REQ-011 SHALL implement states IDLE, REQ, WAIT_RESP, DONE.
REQ-012 IDLE: on data_mem_req_i, SHALL register addr, size, wr, wdata; legal and aligned -> REQ; otherwise -> DONE with error flag set, no bus transaction.
REQ-013 Alignment: half-word requires addr[0]=0; word requires addr[1:0]=0; byte always aligned; size 2'b10 is an error.
REQ-014 REQ: bus_req_o=1 with registered fields stable; on bus_gnt_i -> WAIT_RESP; bus_req_o drops the cycle after the grant.
REQ-015 WAIT_RESP: on bus_rvalid_i -> DONE, capturing bus_rdata_i (loads only) and bus_err_i.
REQ-016 DONE: lasts exactly one cycle; mem_stall_o=0; data_err_o=error flag; then -> IDLE.
REQ-017 mem_stall_o SHALL be data_mem_req_i AND state != DONE (combinational), giving minimum load/store latency of 3 stall cycles (IDLE, REQ with same-cycle grant, WAIT_RESP with same-cycle rvalid).
REQ-018 bus_addr_o SHALL be {addr[31:2],2'b00}; bus_we_o = registered wr.
REQ-019 bus_be_o: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
REQ-020 bus_wdata_o: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-021 mem_rd_data_o SHALL be captured rdata >> (8*addr[1:0]), masked to 8/16/32 bits by size and zero-filled above; held until the next load completes; unchanged by stores.
REQ-022 Timeout counter: cleared on entry to REQ; increments each cycle in REQ/WAIT_RESP; reaching TIMEOUT_CYCLES -> DONE with error flag, bus_req_o dropped, late rvalid ignored in IDLE.
REQ-023 bus_gnt_i or bus_rvalid_i outside the states that expect it SHALL be ignored.
REQ-024 data_mem_req_i dropping mid-transaction SHALL NOT abort the bus transaction; it completes to DONE and returns to IDLE.

Reset
REQ-025 On reset_n low, asynchronously: state IDLE, bus_req_o 0, bus_we_o 0, bus_be_o 0, bus_addr_o 0, bus_wdata_o 0, mem_rd_data_o 0, data_err_o 0, counter 0, error flag 0.
REQ-026 Reset asserted mid-transaction SHALL abandon it; after release, no bus_req_o until a new data_mem_req_i.

Verification
REQ-027 Word load addr 0x100, gnt same cycle, rvalid 1 cycle later, rdata 0xDEADBEEF -> mem_rd_data_o 0xDEADBEEF, stall 3 cycles, data_err_o 0.
REQ-028 Byte store addr 0x203, wdata 0x000000A5 -> bus_addr_o 0x200, bus_be_o 4'b1000, bus_wdata_o 0xA5A5A5A5, bus_we_o 1.
REQ-029 Half load addr 0x102, rdata 0x1234ABCD -> mem_rd_data_o 0x00001234.
REQ-030 Word load addr 0x101 -> no bus_req_o, DONE next cycle, data_err_o pulse 1 cycle.
REQ-031 TIMEOUT_CYCLES=4, gnt never asserted -> bus_req_o high 4 cycles then low, data_err_o pulse, stall released.
REQ-032 reset_n low in WAIT_RESP, then rvalid after release -> state IDLE, mem_rd_data_o stays 0, no data_err_o.
